// File: rtl/vend_ctrl_if.sv
// Vending controller bus: key/tick inputs toward the controller and the
// registered transaction/display values coming back out of it.
interface vend_ctrl_if;
  logic [3:0]  key_pulse;     // [0] select, [1] next/1 yuan, [2] 5 yuan, [3] cancel
  logic        flag_2s;       // one-cycle 2 s timebase tick
  logic [19:0] money_show;    // decimal value for the six-digit display
  logic        flag_charge;   // change is being dispensed
  logic [1:0]  state;         // 0 IDLE, 1 SELECT, 2 PAY, 3 CHANGE
  logic [4:0]  money_pay;     // price of the selected item
  logic [4:0]  money_paid;    // amount inserted so far
  logic [4:0]  money_charge;  // change or refund amount

  // Stimulus side: drives keys and ticks, observes the controller outputs.
  modport master (
    output key_pulse, flag_2s,
    input  money_show, flag_charge, state, money_pay, money_paid, money_charge
  );

  // Controller side.
  modport slave (
    input  key_pulse, flag_2s,
    output money_show, flag_charge, state, money_pay, money_paid, money_charge
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending-machine transaction controller: IDLE/SELECT/PAY/CHANGE flow driven
// by debounced key pulses and a 2 s tick. Every output is registered and
// reflects the key/tick sampled on the previous clock edge.
module vend_ctrl #(
  parameter logic [4:0]  PRICE_A       = 5'd3,
  parameter logic [4:0]  PRICE_B       = 5'd5,
  parameter logic [4:0]  PRICE_C       = 5'd8,
  parameter int unsigned MAX_PAID      = 30,   // must be <= 31
  parameter int unsigned HOLD_TICKS    = 2,
  parameter int unsigned TIMEOUT_TICKS = 5
) (
  input logic        clk,
  input logic        rstn,
  vend_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_PAY    = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ITEM_A = 2'd0,
    ITEM_B = 2'd1,
    ITEM_C = 2'd2
  } item_t;

  // Counter is wide enough for any sensible tick count; it never runs past
  // the larger of the two limits because reaching a limit changes state.
  localparam int                CNT_W     = 8;
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0]  HOLD_C    = CNT_W'(HOLD_TICKS);
  localparam logic [5:0]        MAX_C     = 6'(MAX_PAID);

  // Registered state and outputs
  state_t            r_state;
  item_t             r_item;
  logic [4:0]        r_pay;
  logic [4:0]        r_paid;
  logic [4:0]        r_charge;
  logic [CNT_W-1:0]  r_cnt;
  logic [19:0]       r_show;
  logic              r_flag;

  // Next-state values
  state_t            w_state_next;
  item_t             w_item_next;
  logic [4:0]        w_pay_next;
  logic [4:0]        w_paid_next;
  logic [4:0]        w_charge_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [19:0]       w_show_next;
  logic              w_flag_next;
  logic              w_go_idle;
  logic              w_refund;

  // Decoded keys after priority resolution: cancel > select > 5 yuan > 1 yuan.
  logic              w_k_cancel;
  logic              w_k_sel;
  logic              w_k_five;
  logic              w_k_one;
  logic              w_k_coin;
  logic              w_tick;
  logic [5:0]        w_coin_amt;
  logic [5:0]        w_sum;
  logic [CNT_W-1:0]  w_cnt_inc;
  item_t             w_item_succ;

  function automatic logic [4:0] price_of(input item_t it);
    case (it)
      ITEM_A:  price_of = PRICE_A;
      ITEM_B:  price_of = PRICE_B;
      default: price_of = PRICE_C;
    endcase
  endfunction

  assign w_k_cancel = io_bus.key_pulse[3];
  assign w_k_sel    = ~io_bus.key_pulse[3] & io_bus.key_pulse[0];
  assign w_k_five   = ~io_bus.key_pulse[3] & ~io_bus.key_pulse[0] & io_bus.key_pulse[2];
  assign w_k_one    = ~io_bus.key_pulse[3] & ~io_bus.key_pulse[0] & ~io_bus.key_pulse[2]
                    & io_bus.key_pulse[1];
  assign w_k_coin   = w_k_five | w_k_one;
  assign w_tick     = io_bus.flag_2s;

  // Coin sum kept at 6 bits so an overflow past 31 is caught by the cap test.
  assign w_coin_amt = w_k_five ? 6'd5 : 6'd1;
  assign w_sum      = {1'b0, r_paid} + w_coin_amt;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  // Item rotation A -> B -> C -> A
  always_comb begin
    w_item_succ = ITEM_A;
    case (r_item)
      ITEM_A:  w_item_succ = ITEM_B;
      ITEM_B:  w_item_succ = ITEM_C;
      default: w_item_succ = ITEM_A;
    endcase
  end

  // Next-state and transaction bookkeeping for the flow FSM
  always_comb begin
    w_state_next  = r_state;
    w_item_next   = r_item;
    w_pay_next    = r_pay;
    w_paid_next   = r_paid;
    w_charge_next = r_charge;
    w_cnt_next    = r_cnt;
    w_go_idle     = 1'b0;
    w_refund      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_k_sel) begin
          w_state_next  = ST_SELECT;
          w_item_next   = ITEM_A;
          w_pay_next    = PRICE_A;
          w_paid_next   = 5'd0;
          w_charge_next = 5'd0;
        end
      end

      ST_SELECT: begin
        if (w_k_cancel) begin
          w_go_idle = 1'b1;
        end else if (w_k_sel) begin
          w_state_next = ST_PAY;
          w_paid_next  = 5'd0;
          w_cnt_next   = '0;
        end else if (w_k_one) begin
          w_item_next = w_item_succ;
          w_pay_next  = price_of(w_item_succ);
          w_cnt_next  = '0;
        end else if (w_tick) begin
          // 5 yuan key is meaningless here, so it does not hold off the tick
          if (w_cnt_inc >= TIMEOUT_C) w_go_idle = 1'b1;
          else                        w_cnt_next = w_cnt_inc;
        end
      end

      ST_PAY: begin
        if (w_k_cancel) begin
          w_refund = 1'b1;
        end else if (w_k_coin) begin
          // A rejected coin still counts as activity for the timeout.
          w_cnt_next = '0;
          if (w_sum > MAX_C) begin
            w_paid_next = r_paid;
          end else if (w_sum >= {1'b0, r_pay}) begin
            w_state_next  = ST_CHANGE;
            w_paid_next   = w_sum[4:0];
            w_charge_next = w_sum[4:0] - r_pay;
          end else begin
            w_paid_next = w_sum[4:0];
          end
        end else if (w_tick) begin
          if (w_cnt_inc >= TIMEOUT_C) w_refund = 1'b1;
          else                        w_cnt_next = w_cnt_inc;
        end
      end

      ST_CHANGE: begin
        if (w_tick) begin
          if (w_cnt_inc >= HOLD_C) w_go_idle = 1'b1;
          else                     w_cnt_next = w_cnt_inc;
        end
      end

      default: begin
        w_go_idle = 1'b1;
      end
    endcase

    // Abort from PAY: hand back what was inserted, or go straight home if nothing was.
    if (w_refund) begin
      if (r_paid == 5'd0) begin
        w_go_idle = 1'b1;
      end else begin
        w_state_next  = ST_CHANGE;
        w_charge_next = r_paid;
        w_cnt_next    = '0;
      end
    end

    // Every return to IDLE wipes the transaction.
    if (w_go_idle) begin
      w_state_next  = ST_IDLE;
      w_item_next   = ITEM_A;
      w_pay_next    = 5'd0;
      w_paid_next   = 5'd0;
      w_charge_next = 5'd0;
      w_cnt_next    = '0;
    end
  end

  // Display value and change flag derived from the next state so they line up
  // with the other registered outputs.
  always_comb begin
    w_show_next = 20'd0;
    w_flag_next = 1'b0;
    case (w_state_next)
      ST_IDLE:   w_show_next = 20'd0;
      ST_SELECT: w_show_next = 20'(w_pay_next) * 20'd10000;
      ST_PAY:    w_show_next = 20'(w_pay_next) * 20'd10000 + 20'(w_paid_next);
      ST_CHANGE: begin
        w_show_next = 20'(w_charge_next);
        w_flag_next = (w_charge_next != 5'd0);
      end
      default:   w_show_next = 20'd0;
    endcase
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_item   <= ITEM_A;
      r_pay    <= 5'd0;
      r_paid   <= 5'd0;
      r_charge <= 5'd0;
      r_cnt    <= '0;
      r_show   <= 20'd0;
      r_flag   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_item   <= w_item_next;
      r_pay    <= w_pay_next;
      r_paid   <= w_paid_next;
      r_charge <= w_charge_next;
      r_cnt    <= w_cnt_next;
      r_show   <= w_show_next;
      r_flag   <= w_flag_next;
    end
  end

  assign io_bus.state        = r_state;
  assign io_bus.money_pay    = r_pay;
  assign io_bus.money_paid   = r_paid;
  assign io_bus.money_charge = r_charge;
  assign io_bus.money_show   = r_show;
  assign io_bus.flag_charge  = r_flag;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus pushes hand-computed expected
// outputs, a monitor pops and compares them on the following falling edge.
module tb_vend_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  vend_ctrl_if bus0();
  vend_ctrl_if bus1();

  // Default prices
  vend_ctrl u_dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus0.slave)
  );

  // Item C priced above the payment cap
  vend_ctrl #(
    .PRICE_C  (5'd31),
    .MAX_PAID (30)
  ) u_dut_sat (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus1.slave)
  );

  typedef struct {
    int          dut;
    string       name;
    logic [1:0]  st;
    logic [4:0]  pay;
    logic [4:0]  paid;
    logic [4:0]  chg;
    logic [19:0] show;
    logic        fl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  event mon_kick;

  task automatic push_exp(input int d, input string nm, input logic [1:0] st,
                          input logic [4:0] pay, input logic [4:0] paid,
                          input logic [4:0] chg, input logic [19:0] show,
                          input logic fl);
    exp_t e;
    e.dut  = d;
    e.name = nm;
    e.st   = st;
    e.pay  = pay;
    e.paid = paid;
    e.chg  = chg;
    e.show = show;
    e.fl   = fl;
    sb_q.push_back(e);
  endtask

  // One-cycle stimulus: drive on the falling edge, release just after the rising edge.
  task automatic step(input int d, input logic [3:0] k, input logic t);
    @(negedge clk);
    if (d == 0) begin
      bus0.key_pulse = k;
      bus0.flag_2s   = t;
    end else begin
      bus1.key_pulse = k;
      bus1.flag_2s   = t;
    end
    @(posedge clk);
    #1;
    bus0.key_pulse = 4'd0;
    bus0.flag_2s   = 1'b0;
    bus1.key_pulse = 4'd0;
    bus1.flag_2s   = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the selected DUT.
  initial begin
    exp_t        e;
    logic [1:0]  a_st;
    logic [4:0]  a_pay, a_paid, a_chg;
    logic [19:0] a_show;
    logic        a_fl;
    bit          ok;
    forever begin
      @(negedge clk or mon_kick);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.dut == 0) begin
          a_st = bus0.state; a_pay = bus0.money_pay; a_paid = bus0.money_paid;
          a_chg = bus0.money_charge; a_show = bus0.money_show; a_fl = bus0.flag_charge;
        end else begin
          a_st = bus1.state; a_pay = bus1.money_pay; a_paid = bus1.money_paid;
          a_chg = bus1.money_charge; a_show = bus1.money_show; a_fl = bus1.flag_charge;
        end
        ok = (a_st === e.st) && (a_pay === e.pay) && (a_paid === e.paid) &&
             (a_chg === e.chg) && (a_show === e.show) && (a_fl === e.fl);
        n_checks++;
        if (!ok) begin
          n_errors++;
          $display("FAIL %s: got st=%0d pay=%0d paid=%0d chg=%0d show=%0d flag=%0d, want st=%0d pay=%0d paid=%0d chg=%0d show=%0d flag=%0d",
                   e.name, a_st, a_pay, a_paid, a_chg, a_show, a_fl,
                   e.st, e.pay, e.paid, e.chg, e.show, e.fl);
        end else begin
          $display("ok   %s: st=%0d pay=%0d paid=%0d chg=%0d show=%0d flag=%0d",
                   e.name, a_st, a_pay, a_paid, a_chg, a_show, a_fl);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus, want end before 100000");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    bus0.key_pulse = 4'd0; bus0.flag_2s = 1'b0;
    bus1.key_pulse = 4'd0; bus1.flag_2s = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    push_exp(0, "reset0", 2'd0, 5'd0, 5'd0, 5'd0, 20'd0, 1'b0);
    push_exp(1, "reset1", 2'd0, 5'd0, 5'd0, 5'd0, 20'd0, 1'b0);

    // 1: select and item rotation
    step(0, 4'b0001, 1'b0); push_exp(0, "t1_select",   2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0100, 1'b0); push_exp(0, "t1_5y_ignore",2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t1_item_b",   2'd1, 5'd5, 5'd0, 5'd0, 20'd50000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t1_item_c",   2'd1, 5'd8, 5'd0, 5'd0, 20'd80000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t1_item_a",   2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);

    // 2: item B, pay with change, hold then idle
    step(0, 4'b0010, 1'b0); push_exp(0, "t2_item_b",   2'd1, 5'd5, 5'd0, 5'd0, 20'd50000, 1'b0);
    step(0, 4'b0001, 1'b0); push_exp(0, "t2_pay",      2'd2, 5'd5, 5'd0, 5'd0, 20'd50000, 1'b0);
    step(0, 4'b0001, 1'b0); push_exp(0, "t2_sel_ignore",2'd2,5'd5, 5'd0, 5'd0, 20'd50000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t2_paid1",    2'd2, 5'd5, 5'd1, 5'd0, 20'd50001, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t2_paid2",    2'd2, 5'd5, 5'd2, 5'd0, 20'd50002, 1'b0);
    step(0, 4'b0100, 1'b0); push_exp(0, "t2_change",   2'd3, 5'd5, 5'd7, 5'd2, 20'd2,     1'b1);
    step(0, 4'b0000, 1'b1); push_exp(0, "t2_hold1",    2'd3, 5'd5, 5'd7, 5'd2, 20'd2,     1'b1);
    step(0, 4'b0000, 1'b1); push_exp(0, "t2_idle",     2'd0, 5'd0, 5'd0, 5'd0, 20'd0,     1'b0);

    // Cancel outranks select in IDLE, so nothing happens
    step(0, 4'b1001, 1'b0); push_exp(0, "prio_idle",   2'd0, 5'd0, 5'd0, 5'd0, 20'd0,     1'b0);

    // 3: item C, cancel beats coin in the same cycle
    step(0, 4'b0001, 1'b0); push_exp(0, "t3_select",   2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t3_item_b",   2'd1, 5'd5, 5'd0, 5'd0, 20'd50000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t3_item_c",   2'd1, 5'd8, 5'd0, 5'd0, 20'd80000, 1'b0);
    step(0, 4'b0001, 1'b0); push_exp(0, "t3_pay",      2'd2, 5'd8, 5'd0, 5'd0, 20'd80000, 1'b0);
    step(0, 4'b0100, 1'b0); push_exp(0, "t3_paid5",    2'd2, 5'd8, 5'd5, 5'd0, 20'd80005, 1'b0);
    step(0, 4'b1010, 1'b0); push_exp(0, "t3_cancel",   2'd3, 5'd8, 5'd5, 5'd5, 20'd5,     1'b1);
    step(0, 4'b0000, 1'b1); push_exp(0, "t3_hold1",    2'd3, 5'd8, 5'd5, 5'd5, 20'd5,     1'b1);
    step(0, 4'b0001, 1'b0); push_exp(0, "t3_key_ignore",2'd3,5'd8, 5'd5, 5'd5, 20'd5,     1'b1);
    step(0, 4'b0000, 1'b1); push_exp(0, "t3_idle",     2'd0, 5'd0, 5'd0, 5'd0, 20'd0,     1'b0);
    step(0, 4'b0001, 1'b0); push_exp(0, "t3b_select",  2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0001, 1'b0); push_exp(0, "t3b_pay",     2'd2, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b1000, 1'b0); push_exp(0, "t3b_cancel0", 2'd0, 5'd0, 5'd0, 5'd0, 20'd0,     1'b0);

    // 5: PAY timeout refunds after five quiet ticks
    step(0, 4'b0001, 1'b0); push_exp(0, "t5_select",   2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0001, 1'b0); push_exp(0, "t5_pay",      2'd2, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t5_paid1",    2'd2, 5'd3, 5'd1, 5'd0, 20'd30001, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 4'b0000, 1'b1); push_exp(0, "t5_tick",   2'd2, 5'd3, 5'd1, 5'd0, 20'd30001, 1'b0);
    end
    step(0, 4'b0000, 1'b1); push_exp(0, "t5_timeout",  2'd3, 5'd3, 5'd1, 5'd1, 20'd1,     1'b1);
    step(0, 4'b0000, 1'b1); push_exp(0, "t5_hold1",    2'd3, 5'd3, 5'd1, 5'd1, 20'd1,     1'b1);
    step(0, 4'b0000, 1'b1); push_exp(0, "t5_idle",     2'd0, 5'd0, 5'd0, 5'd0, 20'd0,     1'b0);

    // 5b: a coin on tick 4 restarts the count
    step(0, 4'b0001, 1'b0); push_exp(0, "t5b_select",  2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0001, 1'b0); push_exp(0, "t5b_pay",     2'd2, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t5b_paid1",   2'd2, 5'd3, 5'd1, 5'd0, 20'd30001, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 4'b0000, 1'b1); push_exp(0, "t5b_tick",  2'd2, 5'd3, 5'd1, 5'd0, 20'd30001, 1'b0);
    end
    step(0, 4'b0010, 1'b1); push_exp(0, "t5b_key_tick",2'd2, 5'd3, 5'd2, 5'd0, 20'd30002, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 4'b0000, 1'b1); push_exp(0, "t5b_notimeout",2'd2,5'd3, 5'd2, 5'd0, 20'd30002, 1'b0);
    end
    step(0, 4'b0000, 1'b1); push_exp(0, "t5b_timeout", 2'd3, 5'd3, 5'd2, 5'd2, 20'd2,     1'b1);
    step(0, 4'b0000, 1'b1); push_exp(0, "t5b_hold1",   2'd3, 5'd3, 5'd2, 5'd2, 20'd2,     1'b1);
    step(0, 4'b0000, 1'b1); push_exp(0, "t5b_idle",    2'd0, 5'd0, 5'd0, 5'd0, 20'd0,     1'b0);

    // SELECT timeout returns to IDLE
    step(0, 4'b0001, 1'b0); push_exp(0, "sel_to_select",2'd1,5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 4'b0000, 1'b1); push_exp(0, "sel_to_tick",2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    end
    step(0, 4'b0000, 1'b1); push_exp(0, "sel_to_idle", 2'd0, 5'd0, 5'd0, 5'd0, 20'd0,     1'b0);

    // 4: payment cap on the PRICE_C=31 instance
    step(1, 4'b0001, 1'b0); push_exp(1, "t4_select",   2'd1, 5'd3,  5'd0, 5'd0, 20'd30000,  1'b0);
    step(1, 4'b0010, 1'b0); push_exp(1, "t4_item_b",   2'd1, 5'd5,  5'd0, 5'd0, 20'd50000,  1'b0);
    step(1, 4'b0010, 1'b0); push_exp(1, "t4_item_c",   2'd1, 5'd31, 5'd0, 5'd0, 20'd310000, 1'b0);
    step(1, 4'b0001, 1'b0); push_exp(1, "t4_pay",      2'd2, 5'd31, 5'd0, 5'd0, 20'd310000, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(1, 4'b0100, 1'b0);
      push_exp(1, "t4_coin5", 2'd2, 5'd31, 5'(5 * i), 5'd0, 20'd310000 + 20'(5 * i), 1'b0);
    end
    step(1, 4'b0010, 1'b0); push_exp(1, "t4_reject",   2'd2, 5'd31, 5'd30, 5'd0,  20'd310030, 1'b0);
    step(1, 4'b1000, 1'b0); push_exp(1, "t4_refund",   2'd3, 5'd31, 5'd30, 5'd30, 20'd30,     1'b1);

    // 6: asynchronous reset mid-PAY
    step(0, 4'b0001, 1'b0); push_exp(0, "t6_select",   2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t6_item_b",   2'd1, 5'd5, 5'd0, 5'd0, 20'd50000, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t6_item_c",   2'd1, 5'd8, 5'd0, 5'd0, 20'd80000, 1'b0);
    step(0, 4'b0001, 1'b0); push_exp(0, "t6_pay",      2'd2, 5'd8, 5'd0, 5'd0, 20'd80000, 1'b0);
    step(0, 4'b0100, 1'b0); push_exp(0, "t6_paid5",    2'd2, 5'd8, 5'd5, 5'd0, 20'd80005, 1'b0);
    step(0, 4'b0010, 1'b0); push_exp(0, "t6_paid6",    2'd2, 5'd8, 5'd6, 5'd0, 20'd80006, 1'b0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    push_exp(0, "t6_async_rst", 2'd0, 5'd0, 5'd0, 5'd0, 20'd0, 1'b0);
    -> mon_kick;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step(0, 4'b0001, 1'b0); push_exp(0, "t6_after_rst",2'd1, 5'd3, 5'd0, 5'd0, 20'd30000, 1'b0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Vending-machine transaction controller for the auto_bug_fpga vending design. It consumes single-cycle debounced key pulses and the 2 s timebase tick, and runs the IDLE/SELECT/PAY/CHANGE flow. It produces the decimal value the downstream six-digit seven-segment display stage shows, plus the change-dispense flag. It sits directly upstream of the display block and supplies its money_show and flag_charge.

Parameters:
PRICE_A, 3, price of item A in yuan (5-bit)
PRICE_B, 5, price of item B in yuan
PRICE_C, 8, price of item C in yuan
MAX_PAID, 30, cap on accumulated payment in yuan (must be <= 31)
HOLD_TICKS, 2, flag_2s ticks spent in CHANGE before returning to IDLE
TIMEOUT_TICKS, 5, flag_2s ticks with no key in SELECT/PAY before abort

Ports:
clk  input  1  system clock
rstn  input  1  reset; asynchronous, active-low
key_pulse  input  4  one-cycle debounced key pulses: [0] select/confirm, [1] next item / insert 1 yuan, [2] insert 5 yuan, [3] cancel
flag_2s  input  1  one-cycle tick every 2 s
money_show  output  20  decimal value for the display, 0..999999
flag_charge  output  1  high while in CHANGE with money_charge > 0
state  output  2  0 IDLE, 1 SELECT, 2 PAY, 3 CHANGE
money_pay  output  5  price of the selected item
money_paid  output  5  amount inserted so far
money_charge  output  5  change or refund amount

Behaviour:
- Reset (async, rstn low): state=IDLE, item index=A, money_pay=0, money_paid=0, money_charge=0, tick counter=0, money_show=0, flag_charge=0.
- All outputs are registered. They update on the clock edge that samples the key pulse or tick, so they are visible 1 cycle after the pulse.
- Key priority within one cycle: [3] > [0] > [2] > [1]. Only the highest-priority key is acted on; the rest are dropped.
- Tick counter: cleared on every state change and on every accepted key. Otherwise it increments on flag_2s.
- IDLE: money_show=0. key[0] -> SELECT with item=A and money_pay=PRICE_A. All other keys and ticks are ignored.
- SELECT: key[1] cycles the item A->B->C->A and loads money_pay with the matching price. key[0] -> PAY with money_paid=0. key[3] -> IDLE. TIMEOUT_TICKS ticks -> IDLE. key[2] is ignored. money_show = money_pay*10000.
- PAY: key[1] adds 1 and key[2] adds 5 to money_paid.
  - A coin is rejected (paid unchanged, counter still cleared) if the new sum would exceed MAX_PAID.
  - If the new paid >= money_pay, go to CHANGE on the same edge: money_paid takes the new sum, money_charge = new paid - money_pay.
  - key[3] or timeout -> CHANGE with money_charge = money_paid (refund). If money_paid = 0, go to IDLE instead.
  - key[0] is ignored.
  - money_show = money_pay*10000 + money_paid. The display shows "PP00AA".
- CHANGE: money_show = money_charge. flag_charge = (money_charge != 0). Keys are ignored. After HOLD_TICKS ticks -> IDLE, clearing money_pay, money_paid, money_charge and the item index.
- Arithmetic: the sum is computed at 6 bits before the compare, so there is no 5-bit wrap. The money_show multiply is done at 20 bits.
- A tick and an accepted key in the same cycle: the key wins and the counter clears.
- Reset mid-transaction: immediate return to the reset values, with no refund indication.

Test Plan:
1. Reset, then key[0] -> state=1, money_show=30000. key[1] x2 -> money_pay=8, money_show=80000. Third key[1] -> money_pay=3.
2. Item B (5): key[0], then key[1] x2 -> money_show=50002. key[2] -> state=3, money_paid=7, money_charge=2, money_show=2, flag_charge=1. Two flag_2s ticks -> state=0, all outputs 0.
3. Item C (8): key[0], then key[2]. On the next cycle drive key[3]+key[1] together -> cancel wins: state=3, money_charge=5. Separately, cancel with paid=0 -> state=0 directly.
4. Saturation: set money_pay to 31 by forcing the PRICE_C parameter to 31 with MAX_PAID=30, then insert key[2] x6 -> money_paid=30. A further key[1] is rejected (money_paid stays 30) and state stays 2.
5. Timeout: enter PAY, insert 1, apply 5 flag_2s ticks with no keys -> CHANGE with money_charge=1. Repeat with 4 ticks plus a key[1] on tick 4 -> the counter resets and there is no timeout.
6. Assert rstn low mid-PAY (paid=6) asynchronously -> all outputs 0 before the next clk edge. Then key[0] after release is accepted normally.
